// File: rtl/ap_line_sequencer_if.sv
// Bundle for the decoder op handshake and the Ap/Data line request strobes.
// The master modport is the sequencer's own view; slave is the decoder/line side.
interface ap_line_sequencer_if #(
  parameter int CNT_W  = 4,
  parameter int DATA_W = 10
);
  logic              OpValid;
  logic              OpReady;
  logic [2:0]        Opcode;
  logic [CNT_W-1:0]  RepeatCount;
  logic              OpDone;
  logic              OpErr;
  logic              LineReady;
  logic              ApCountAck;
  logic              DataCountAck;
  logic              DataWriteAck;
  logic              CounterReverse;
  logic [DATA_W-1:0] LineData;
  logic [DATA_W-1:0] OutData;
  logic              OutStrobe;

  modport master (
    input  OpValid, Opcode, RepeatCount, LineReady, LineData,
    output OpReady, OpDone, OpErr, ApCountAck, DataCountAck, DataWriteAck,
           CounterReverse, OutData, OutStrobe
  );

  modport slave (
    output OpValid, Opcode, RepeatCount, LineReady, LineData,
    input  OpReady, OpDone, OpErr, ApCountAck, DataCountAck, DataWriteAck,
           CounterReverse, OutData, OutStrobe
  );
endinterface

// File: rtl/ap_line_sequencer.sv
// Turns one decoded data-path op plus repeat count into paced Ap/Data line
// requests, capturing line data for OUT and reporting done/error to the decoder.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | OpReady high, waiting for an op from the decoder
// PRE      | op latched, waiting for the line to report Ready
// ISSUE    | one ack held until the line drops Ready (request taken)
// WAIT     | acks low, waiting for Ready to return; counts a step done
// CAPTURE  | OUT only: sample LineData into OutData
// DONE     | completion; OpDone/OpErr pulse on the following cycle
module ap_line_sequencer #(
  parameter int CNT_W   = 4,
  parameter int DATA_W  = 10,
  parameter int TIMEOUT = 255
) (
  input logic                 Clk,
  input logic                 Rst_n,
  ap_line_sequencer_if.master bus
);

  localparam int TMR_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_DEC   = 3'b010;
  localparam logic [2:0] OP_RIGHT = 3'b011;
  localparam logic [2:0] OP_LEFT  = 3'b100;
  localparam logic [2:0] OP_IN    = 3'b101;
  localparam logic [2:0] OP_OUT   = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE     = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              err_q, err_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              op_ready_q, op_ready_d;
  logic              op_done_q, op_done_d;
  logic              op_err_q, op_err_d;
  logic              ap_ack_q, ap_ack_d;
  logic              dc_ack_q, dc_ack_d;
  logic              dw_ack_q, dw_ack_d;
  logic              rev_q, rev_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_strobe_q, out_strobe_d;

  logic tmr_hit;
  logic tmr_run;
  logic in_step;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      rem_q        <= '0;
      err_q        <= 1'b0;
      tmr_q        <= '0;
      op_ready_q   <= 1'b1;
      op_done_q    <= 1'b0;
      op_err_q     <= 1'b0;
      ap_ack_q     <= 1'b0;
      dc_ack_q     <= 1'b0;
      dw_ack_q     <= 1'b0;
      rev_q        <= 1'b0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rem_q        <= rem_d;
      err_q        <= err_d;
      tmr_q        <= tmr_d;
      op_ready_q   <= op_ready_d;
      op_done_q    <= op_done_d;
      op_err_q     <= op_err_d;
      ap_ack_q     <= ap_ack_d;
      dc_ack_q     <= dc_ack_d;
      dw_ack_q     <= dw_ack_d;
      rev_q        <= rev_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rem_d      = rem_q;
    err_d      = err_q;
    out_data_d = out_data_q;
    tmr_hit    = (tmr_q == TMR_LAST);
    tmr_run    = (state_q == S_PRE) || (state_q == S_ISSUE) || (state_q == S_WAIT);

    case (state_q)
      S_IDLE: begin
        if (bus.OpValid && op_ready_q) begin
          op_d  = bus.Opcode;
          err_d = 1'b0;
          rem_d = (bus.RepeatCount == '0) ? REM_ONE : bus.RepeatCount;
          case (bus.Opcode)
            OP_NOP:        state_d = S_DONE;
            OP_IN, OP_OUT: begin
              rem_d   = REM_ONE;
              state_d = S_PRE;
            end
            OP_INC, OP_DEC, OP_RIGHT, OP_LEFT: state_d = S_PRE;
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_PRE: begin
        if (bus.LineReady) begin
          state_d = (op_q == OP_OUT) ? S_CAPTURE : S_ISSUE;
        end else if (tmr_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_ISSUE: begin
        // A real line acceptance takes priority over a coincident timeout.
        if (!bus.LineReady) begin
          state_d = S_WAIT;
        end else if (tmr_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (bus.LineReady) begin
          rem_d   = rem_q - REM_ONE;
          state_d = (rem_q == REM_ONE) ? S_DONE : S_ISSUE;
        end else if (tmr_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_CAPTURE: begin
        out_data_d = bus.LineData;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) || !tmr_run) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end

    // Acks and direction are decoded from the next state so they switch on the
    // same edge as the state itself and stay glitch-free.
    in_step      = (state_d == S_PRE) || (state_d == S_ISSUE) || (state_d == S_WAIT);
    op_ready_d   = (state_d == S_IDLE);
    ap_ack_d     = (state_d == S_ISSUE) && ((op_d == OP_RIGHT) || (op_d == OP_LEFT));
    dc_ack_d     = (state_d == S_ISSUE) && ((op_d == OP_INC) || (op_d == OP_DEC));
    dw_ack_d     = (state_d == S_ISSUE) && (op_d == OP_IN);
    rev_d        = in_step && ((op_d == OP_DEC) || (op_d == OP_LEFT));
    out_strobe_d = (state_q == S_CAPTURE);
    op_done_d    = (state_q == S_DONE);
    op_err_d     = (state_q == S_DONE) && err_q;
  end

  assign bus.OpReady        = op_ready_q;
  assign bus.OpDone         = op_done_q;
  assign bus.OpErr          = op_err_q;
  assign bus.ApCountAck     = ap_ack_q;
  assign bus.DataCountAck   = dc_ack_q;
  assign bus.DataWriteAck   = dw_ack_q;
  assign bus.CounterReverse = rev_q;
  assign bus.OutData        = out_data_q;
  assign bus.OutStrobe      = out_strobe_q;

endmodule

// File: tb/tb_ap_line_sequencer.sv
// Directed bench for ap_line_sequencer: a responsive line model, an ack/strobe
// monitor, and a scoreboard of expected per-op results checked at OpDone.
module tb_ap_line_sequencer;

  localparam int CNT_W   = 4;
  localparam int DATA_W  = 10;
  localparam int TIMEOUT = 255;
  localparam int LOW_CYC = 2;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_DEC   = 3'b010;
  localparam logic [2:0] OP_RIGHT = 3'b011;
  localparam logic [2:0] OP_LEFT  = 3'b100;
  localparam logic [2:0] OP_IN    = 3'b101;
  localparam logic [2:0] OP_OUT   = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  typedef struct {
    int          ap;
    int          dc;
    int          dw;
    int          strobes;
    int          err;
    int          hi;
    logic [9:0]  data;
  } exp_t;

  logic Clk;
  logic Rst_n;
  ap_line_sequencer_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) bus ();

  ap_line_sequencer #(.CNT_W(CNT_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.master)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int ap_p, dc_p, dw_p, ap_hi, strobes, done_p, rev_bad, multi_bad, err_bad;
  logic [9:0] cap_data;
  logic prev_ap, prev_dc, prev_dw;
  bit   exp_rev;
  bit   line_stuck;
  int   lr_busy;
  bit   lr_pend;
  exp_t sb[$];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    ap_p = 0; dc_p = 0; dw_p = 0; ap_hi = 0; strobes = 0;
    done_p = 0; rev_bad = 0; multi_bad = 0; err_bad = 0; cap_data = '0;
  endtask

  // Monitor first, then the line model: Ready drops one cycle after it sees an
  // ack, stays low LOW_CYC cycles, then returns.
  initial begin
    int nacks;
    bus.LineReady = 1'b1;
    prev_ap = 0; prev_dc = 0; prev_dw = 0;
    lr_busy = 0; lr_pend = 0;
    forever begin
      @(negedge Clk);
      if (bus.ApCountAck === 1'b1 && !prev_ap) ap_p++;
      if (bus.DataCountAck === 1'b1 && !prev_dc) dc_p++;
      if (bus.DataWriteAck === 1'b1 && !prev_dw) dw_p++;
      prev_ap = (bus.ApCountAck === 1'b1);
      prev_dc = (bus.DataCountAck === 1'b1);
      prev_dw = (bus.DataWriteAck === 1'b1);
      if (prev_ap) ap_hi++;
      nacks = int'(prev_ap) + int'(prev_dc) + int'(prev_dw);
      if (nacks > 1) multi_bad++;
      if (nacks > 0 && bus.CounterReverse !== exp_rev) rev_bad++;
      if (bus.OpReady === 1'b1 && bus.CounterReverse !== 1'b0) rev_bad++;
      if (bus.OutStrobe === 1'b1) begin
        strobes++;
        cap_data = bus.OutData;
      end
      if (bus.OpDone === 1'b1) done_p++;
      if (bus.OpErr === 1'b1 && bus.OpDone !== 1'b1) err_bad++;

      if (!Rst_n || line_stuck) begin
        bus.LineReady = 1'b1;
        lr_busy = 0;
        lr_pend = 0;
      end else if (lr_busy > 0) begin
        lr_busy--;
        if (lr_busy == 0) bus.LineReady = 1'b1;
      end else if (lr_pend) begin
        bus.LineReady = 1'b0;
        lr_busy = LOW_CYC;
        lr_pend = 0;
      end else if (nacks > 0 && bus.LineReady) begin
        lr_pend = 1;
      end
    end
  end

  task automatic do_op(input string name, input logic [2:0] op, input logic [3:0] cnt,
                       input logic [9:0] lval, input bit stuck, input int exp_lat);
    exp_t e;
    exp_t got;
    int   n;
    int   t;
    int   acc;
    bit   done_seen;
    logic err_obs;
    n = (cnt == 0) ? 1 : int'(cnt);
    e = '{ap: 0, dc: 0, dw: 0, strobes: 0, err: 0, hi: -1, data: '0};
    case (op)
      OP_INC, OP_DEC:    e.dc = n;
      OP_RIGHT, OP_LEFT: e.ap = n;
      OP_IN:             e.dw = 1;
      OP_OUT: begin
        e.strobes = 1;
        e.data    = lval;
      end
      OP_RSVD:           e.err = 1;
      default: ;
    endcase
    if (stuck) begin
      e.err = 1;
      if (op == OP_RIGHT || op == OP_LEFT) begin
        e.ap = 1;
        e.hi = TIMEOUT;
      end
      if (op == OP_INC || op == OP_DEC) e.dc = 1;
    end
    sb.push_back(e);

    @(posedge Clk);
    clear_mon();
    exp_rev      = (op == OP_DEC) || (op == OP_LEFT);
    line_stuck   = stuck;
    bus.LineData = lval;
    @(negedge Clk);
    bus.OpValid     = 1'b1;
    bus.Opcode      = op;
    bus.RepeatCount = cnt;
    t = 0;
    while (bus.OpReady !== 1'b1 && t < 50) begin
      @(negedge Clk);
      t++;
    end
    check({name, " accepted"}, 32'(bus.OpReady === 1'b1), 32'd1);
    acc = cyc;
    @(negedge Clk);
    bus.OpValid     = 1'b0;
    bus.Opcode      = 3'($urandom_range(0, 7));
    bus.RepeatCount = 4'($urandom_range(0, 15));

    t = 0;
    while (bus.OpDone !== 1'b1 && t < 2000) begin
      @(negedge Clk);
      t++;
    end
    done_seen = (bus.OpDone === 1'b1);
    err_obs   = bus.OpErr;
    check({name, " done_seen"}, 32'(done_seen), 32'd1);
    if (exp_lat >= 0) check({name, " latency"}, 32'(cyc - acc), 32'(exp_lat));
    #1;
    got = sb.pop_front();
    check({name, " OpErr"}, 32'(err_obs), 32'(got.err));
    check({name, " ap_pulses"}, 32'(ap_p), 32'(got.ap));
    check({name, " dc_pulses"}, 32'(dc_p), 32'(got.dc));
    check({name, " dw_pulses"}, 32'(dw_p), 32'(got.dw));
    check({name, " strobes"}, 32'(strobes), 32'(got.strobes));
    if (got.strobes > 0) check({name, " OutData"}, 32'(cap_data), 32'(got.data));
    if (got.hi >= 0) check({name, " ack_high_cycles"}, 32'(ap_hi), 32'(got.hi));
    check({name, " reverse_ok"}, 32'(rev_bad), 32'd0);
    check({name, " one_ack"}, 32'(multi_bad), 32'd0);
    @(negedge Clk);
    #1;
    check({name, " OpDone_one_cycle"}, 32'(bus.OpDone), 32'd0);
    check({name, " OpReady_back"}, 32'(bus.OpReady), 32'd1);
    check({name, " done_pulses"}, 32'(done_p), 32'd1);
    check({name, " err_alone"}, 32'(err_bad), 32'd0);
    line_stuck = 0;
  endtask

  initial begin
    int t;
    Rst_n           = 1'b0;
    bus.OpValid     = 1'b0;
    bus.Opcode      = OP_NOP;
    bus.RepeatCount = '0;
    bus.LineData    = '0;
    line_stuck      = 0;
    exp_rev         = 0;
    clear_mon();
    repeat (3) @(negedge Clk);
    check("rst OpReady", 32'(bus.OpReady), 32'd1);
    check("rst acks", 32'({bus.ApCountAck, bus.DataCountAck, bus.DataWriteAck}), 32'd0);
    check("rst CounterReverse", 32'(bus.CounterReverse), 32'd0);
    check("rst OpDone_OpErr", 32'({bus.OpDone, bus.OpErr}), 32'd0);
    check("rst OutData", 32'(bus.OutData), 32'd0);
    check("rst OutStrobe", 32'(bus.OutStrobe), 32'd0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    do_op("inc3",    OP_INC,   4'd3,  10'h000, 0, -1);
    do_op("left0",   OP_LEFT,  4'd0,  10'h000, 0, -1);
    do_op("out2a5",  OP_OUT,   4'd4,  10'h2A5, 0, -1);
    do_op("in7",     OP_IN,    4'd7,  10'h000, 0, -1);
    do_op("rsvd",    OP_RSVD,  4'd2,  10'h000, 0, 2);
    do_op("nop",     OP_NOP,   4'd5,  10'h000, 0, 2);
    do_op("dec2",    OP_DEC,   4'd2,  10'h000, 0, -1);
    do_op("out15a",  OP_OUT,   4'd0,  10'h15A, 0, -1);
    check("OutData held", 32'(bus.OutData), 32'h15A);
    do_op("right15", OP_RIGHT, 4'd15, 10'h000, 0, -1);

    // Reset in the middle of a 5-step INC.
    @(posedge Clk);
    clear_mon();
    exp_rev = 0;
    @(negedge Clk);
    bus.OpValid     = 1'b1;
    bus.Opcode      = OP_INC;
    bus.RepeatCount = 4'd5;
    @(negedge Clk);
    bus.OpValid = 1'b0;
    t = 0;
    while (!(dc_p >= 2 && bus.DataCountAck === 1'b1) && t < 100) begin
      @(negedge Clk);
      t++;
    end
    check("midrst reached_issue", 32'(bus.DataCountAck), 32'd1);
    Rst_n = 1'b0;
    #1;
    check("midrst acks_drop", 32'({bus.ApCountAck, bus.DataCountAck, bus.DataWriteAck}), 32'd0);
    check("midrst OpReady", 32'(bus.OpReady), 32'd1);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (30) @(negedge Clk);
    #1;
    check("midrst no_OpDone", 32'(done_p), 32'd0);
    check("midrst idle_OpReady", 32'(bus.OpReady), 32'd1);

    do_op("right_to", OP_RIGHT, 4'd1, 10'h000, 1, -1);
    do_op("inc1",     OP_INC,   4'd1, 10'h000, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
